// File: rtl/router_nic_port_if.sv
// rtl/router_nic_port_if.sv - NIC link and crossbar handshake bundle for router_nic_port
interface router_nic_port_if #(
    parameter int PACKET_WIDTH = 64
);
    logic                    nic_so;
    logic [PACKET_WIDTH-1:0] nic_do;
    logic                    nic_ro;
    logic                    nic_si;
    logic [PACKET_WIDTH-1:0] nic_di;
    logic                    nic_ri;
    logic                    nic_polarity;
    logic                    xin_valid;
    logic [PACKET_WIDTH-1:0] xin_data;
    logic                    xin_ready;
    logic                    xout_valid;
    logic [PACKET_WIDTH-1:0] xout_data;
    logic                    xout_ready;

    // The router port itself
    modport slave (
        input  nic_so, nic_do, nic_ri, xin_ready, xout_valid, xout_data,
        output nic_ro, nic_si, nic_di, nic_polarity, xin_valid, xin_data, xout_ready
    );

    // The NIC plus crossbar side driving the port
    modport master (
        output nic_so, nic_do, nic_ri, xin_ready, xout_valid, xout_data,
        input  nic_ro, nic_si, nic_di, nic_polarity, xin_valid, xin_data, xout_ready
    );
endinterface

// File: rtl/router_nic_port.sv
// rtl/router_nic_port.sv - router-side NIC endpoint; optional packet counters via ROUTER_NIC_PORT_PKT_CNT_EN
module router_nic_port #(
    parameter int PACKET_WIDTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    router_nic_port_if.slave  bus
`ifdef ROUTER_NIC_PORT_PKT_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [15:0]       rx_count,
    output logic [15:0]       tx_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_FULL  = 2'd2
    } ing_state_t;

    logic                    polarity_q;
    ing_state_t              state_q, state_d;
    logic                    capture;
    logic [PACKET_WIDTH-1:0] buf_q;

    logic [PACKET_WIDTH-1:0] mem_q [2];
    logic                    wr_ptr_q, rd_ptr_q;
    logic [1:0]              count_q;
    logic                    push, pop;

    // Link polarity flips on every edge: odd phases grant ingress, even phases send egress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) polarity_q <= 1'b0;
        else       polarity_q <= ~polarity_q;
    end

    // Ingress next-state: grant in odd phase, one-cycle grant window, hold until crossbar takes it
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE:  if (polarity_q) state_d = ST_GRANT;
            ST_GRANT: begin
                if (bus.nic_so) begin
                    state_d = ST_FULL;
                    capture = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FULL:  if (bus.xin_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Ingress state and single-entry buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) buf_q <= bus.nic_do;
        end
    end

    // nic_ro/xout_ready are masked during reset so every output reads 0 while it is held
    assign bus.nic_ro       = ~reset & (state_q == ST_IDLE);
    assign bus.xin_valid    = (state_q == ST_FULL);
    assign bus.xin_data     = bus.xin_valid ? buf_q : '0;
    assign bus.nic_polarity = polarity_q;

    assign bus.xout_ready = ~reset & (count_q < 2'd2);
    assign bus.nic_si     = (count_q != 2'd0) & ~polarity_q;
    assign bus.nic_di     = bus.nic_si ? mem_q[rd_ptr_q] : '0;
    assign push           = bus.xout_valid & bus.xout_ready;
    assign pop            = bus.nic_si & bus.nic_ri;

    // Egress two-entry circular FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.xout_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef ROUTER_NIC_PORT_PKT_CNT_EN
    logic [15:0] rx_cnt_q, tx_cnt_q;

    // Saturating transfer counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_cnt_q <= 16'd0;
            tx_cnt_q <= 16'd0;
        end else if (cnt_clr) begin
            rx_cnt_q <= 16'd0;
            tx_cnt_q <= 16'd0;
        end else begin
            if (capture && rx_cnt_q != 16'hFFFF) rx_cnt_q <= rx_cnt_q + 16'd1;
            if (pop && tx_cnt_q != 16'hFFFF)     tx_cnt_q <= tx_cnt_q + 16'd1;
        end
    end

    assign rx_count = rx_cnt_q;
    assign tx_count = tx_cnt_q;
`endif

endmodule

// File: tb/tb_router_nic_port.sv
// tb/tb_router_nic_port.sv - self-checking bench for router_nic_port
module tb_router_nic_port;
    localparam int W = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    router_nic_port_if #(.PACKET_WIDTH(W)) bus ();

`ifdef ROUTER_NIC_PORT_PKT_CNT_EN
    logic        cnt_clr;
    logic [15:0] rx_count, tx_count;
`endif

    router_nic_port #(.PACKET_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ROUTER_NIC_PORT_PKT_CNT_EN
        ,
        .cnt_clr  (cnt_clr),
        .rx_count (rx_count),
        .tx_count (tx_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [199:0] pk(input logic ro, input logic si, input logic pol,
                                        input logic xv, input logic xr,
                                        input logic [63:0] di, input logic [63:0] xd);
        return {67'b0, ro, si, pol, xv, xr, di, xd};
    endfunction

    function automatic logic [199:0] dut_out();
        return pk(bus.nic_ro, bus.nic_si, bus.nic_polarity, bus.xin_valid, bus.xout_ready,
                  bus.nic_di, bus.xin_data);
    endfunction

    // Reference model: phase counter, grant/hold flags and a packet queue
    int          m_cyc;
    bit          m_hold, m_grant;
    logic [63:0] m_buf;
    logic [63:0] m_q[$];
    int          m_rx, m_tx;

    task automatic model_reset();
        m_cyc = 0; m_hold = 0; m_grant = 0; m_buf = '0; m_q.delete(); m_rx = 0; m_tx = 0;
    endtask

    function automatic logic [199:0] model_out();
        bit          pol = (m_cyc % 2) == 1;
        bit          si  = (m_q.size() > 0) && !pol;
        logic [63:0] di  = si ? m_q[0] : 64'd0;
        return pk(!m_hold && !m_grant, si, pol, m_hold, m_q.size() < 2, di,
                  m_hold ? m_buf : 64'd0);
    endfunction

    task automatic model_step();
        bit pol  = (m_cyc % 2) == 1;
        bit pop  = (m_q.size() > 0) && !pol && bus.nic_ri;
        bit push = bus.xout_valid && (m_q.size() < 2);
        bit cap  = 0;
        if (m_hold) begin
            if (bus.xin_ready) m_hold = 0;
        end else if (m_grant) begin
            m_grant = 0;
            if (bus.nic_so) begin m_hold = 1; m_buf = bus.nic_do; cap = 1; end
        end else if (pol) begin
            m_grant = 1;
        end
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(bus.xout_data);
`ifdef ROUTER_NIC_PORT_PKT_CNT_EN
        if (cnt_clr) begin m_rx = 0; m_tx = 0; end
        else begin
            if (cap && m_rx < 65535) m_rx++;
            if (pop && m_tx < 65535) m_tx++;
        end
`endif
        m_cyc++;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    task automatic drive(input bit so, input logic [63:0] dat, input bit ri,
                         input bit xrdy, input bit xv, input logic [63:0] xd);
        bus.nic_so = so; bus.nic_do = dat; bus.nic_ri = ri;
        bus.xin_ready = xrdy; bus.xout_valid = xv; bus.xout_data = xd;
    endtask

    typedef struct {
        bit so; logic [63:0] dat; bit ri; bit xrdy; bit xv; logic [63:0] xd;
        bit ro; bit si; bit pol; bit xval; bit xr; logic [63:0] di; logic [63:0] xdat;
    } vec_t;

    vec_t tbl[19];

    task automatic setv(input int i, input bit so, input logic [63:0] dat, input bit ri,
                        input bit xrdy, input bit xv, input logic [63:0] xd,
                        input bit ro, input bit si, input bit pol, input bit xval, input bit xr,
                        input logic [63:0] di, input logic [63:0] xdat);
        tbl[i] = '{so, dat, ri, xrdy, xv, xd, ro, si, pol, xval, xr, di, xdat};
    endtask

    initial begin
        bit filled;
        // inputs: so, do, ri, xrdy, xv, xd | expected: ro, si, pol, xin_valid, xout_ready, di, xin_data
        setv( 0, 0, 0, 0, 0, 0, 0,        1, 0, 1, 0, 1, 0, 0);
        setv( 1, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 0, 0);
        setv( 2, 0, 0, 0, 0, 0, 0,        1, 0, 1, 0, 1, 0, 0);
        setv( 3, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 0, 0);
        setv( 4, 1, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 64'hDEAD_BEEF_0000_0001);
        setv( 5, 1, 64'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 64'hDEAD_BEEF_0000_0001);
        setv( 6, 0, 0, 0, 1, 0, 0,        1, 0, 1, 0, 1, 0, 0);
        setv( 7, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 0, 0);
        setv( 8, 1, 0, 0, 0, 0, 0,        0, 0, 1, 1, 1, 0, 0);
        setv( 9, 0, 0, 0, 1, 0, 0,        1, 0, 0, 0, 1, 0, 0);
        setv(10, 0, 0, 0, 0, 1, 64'hA1,   1, 0, 1, 0, 1, 0, 0);
        setv(11, 0, 0, 0, 0, 1, 64'hA2,   0, 1, 0, 0, 0, 64'hA1, 0);
        setv(12, 0, 0, 0, 0, 0, 0,        1, 0, 1, 0, 0, 0, 0);
        setv(13, 0, 0, 1, 0, 1, 64'hA3,   0, 1, 0, 0, 0, 64'hA1, 0);
        setv(14, 0, 0, 1, 0, 1, 64'hA3,   1, 0, 1, 0, 1, 0, 0);
        setv(15, 0, 0, 1, 0, 1, 64'hA3,   0, 1, 0, 0, 0, 64'hA2, 0);
        setv(16, 0, 0, 1, 0, 0, 0,        1, 0, 1, 0, 1, 0, 0);
        setv(17, 0, 0, 1, 0, 0, 0,        0, 1, 0, 0, 1, 64'hA3, 0);
        setv(18, 0, 0, 1, 0, 0, 0,        1, 0, 1, 0, 1, 0, 0);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
`ifdef ROUTER_NIC_PORT_PKT_CNT_EN
        cnt_clr = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", dut_out(), 200'd0);
        reset = 1'b0;
        #1;
        check("post_release", dut_out(), pk(1, 0, 0, 0, 1, 0, 0));

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].so, tbl[i].dat, tbl[i].ri, tbl[i].xrdy, tbl[i].xv, tbl[i].xd);
            cycle();
            check($sformatf("vec%0d", i), dut_out(),
                  pk(tbl[i].ro, tbl[i].si, tbl[i].pol, tbl[i].xval, tbl[i].xr, tbl[i].di, tbl[i].xdat));
        end
`ifdef ROUTER_NIC_PORT_PKT_CNT_EN
        check("rx_after_table", {184'd0, rx_count}, {184'd0, 16'd2});
        check("tx_after_table", {184'd0, tx_count}, {184'd0, 16'd3});
`endif

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom},
                  $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, {$urandom, $urandom});
`ifdef ROUTER_NIC_PORT_PKT_CNT_EN
            cnt_clr = ($urandom_range(0, 19) == 0);
`endif
            cycle();
            check("random", dut_out(), model_out());
`ifdef ROUTER_NIC_PORT_PKT_CNT_EN
            check("rx_count", {184'd0, rx_count}, {184'd0, 16'(m_rx)});
            check("tx_count", {184'd0, tx_count}, {184'd0, 16'(m_tx)});
`endif
        end
`ifdef ROUTER_NIC_PORT_PKT_CNT_EN
        cnt_clr = 1'b0;
`endif

        // Fill ingress buffer and both egress slots, then reset asynchronously
        filled = 0;
        for (int i = 0; i < 12 && !filled; i++) begin
            drive(1, 64'h5555_0000_0000_0001 + 64'(i), 0, 0, 1, 64'hB0 + 64'(i));
            cycle();
            filled = m_hold && (m_q.size() == 2);
        end
        check("fill_state", {198'd0, bus.xin_valid, bus.xout_ready}, {198'd0, 2'b10});
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", dut_out(), 200'd0);
`ifdef ROUTER_NIC_PORT_PKT_CNT_EN
        check("cnt_reset", {168'd0, rx_count, tx_count}, 200'd0);
`endif
        drive(0, 0, 1, 0, 0, 0);
        model_reset();
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check("post_release2", dut_out(), pk(1, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("si_after_reset", {199'd0, bus.nic_si}, 200'd0);
            check("after_reset_model", dut_out(), model_out());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
